// File: rtl/carbonio_pkg.sv
// CarbonIO shared constants: interrupt source indices, compat-window register
// offsets for the interrupt controller, and the interrupt ID width.
package carbonio_pkg;

  // Interrupt source indices (fixed priority, lowest index wins)
  localparam int CARBONIO_IRQ_SRC_UART_RX = 0;
  localparam int CARBONIO_IRQ_SRC_UART_TX = 1;
  localparam int CARBONIO_IRQ_SRC_PIO0    = 2;
  localparam int CARBONIO_IRQ_SRC_PIO1    = 3;
  localparam int CARBONIO_IRQ_SRC_TIMER0  = 4;
  localparam int CARBONIO_IRQ_SRC_TIMER1  = 5;
  localparam int CARBONIO_IRQ_N_SRC       = 6;

  // Compat-window register offsets
  localparam logic [31:0] CARBONIO_COMPAT_IRQ_ENABLE_OFF  = 32'h70;
  localparam logic [31:0] CARBONIO_COMPAT_IRQ_PENDING_OFF = 32'h74;
  localparam logic [31:0] CARBONIO_COMPAT_IRQ_MASK_OFF    = 32'h78;
  localparam logic [31:0] CARBONIO_COMPAT_IRQ_HOLDOFF_OFF = 32'h7C;

  localparam int CARBONIO_IRQ_ID_W = 5;

  // Every source is rising-edge triggered unless a build overrides it
  localparam logic [CARBONIO_IRQ_N_SRC-1:0] CARBONIO_IRQ_SRC_EDGE_DFLT = 6'b111111;

endpackage

// File: rtl/carbonio_irq_prio_enc.sv
// Lowest-set-bit priority encoder: bit 0 has the highest priority.
// Ports:
//   vec_i    N-bit request vector
//   idx_o    index of the lowest set bit (0 when nothing is set)
//   valid_o  at least one bit of vec_i is set
module carbonio_irq_prio_enc #(
  parameter int N    = 6,
  parameter int ID_W = 5
) (
  input  logic [N-1:0]    vec_i,
  output logic [ID_W-1:0] idx_o,
  output logic            valid_o
);

  // Scan downward so the last hit, which is the lowest index, is what remains
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o   = ID_W'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/carbonio_irq_ctrl.sv
// CarbonIO interrupt controller. Latches per-source events into a pending
// register, gates them with enable and mask, and drives one registered
// interrupt line plus the lowest-index active source ID to the CPU.
//
// Registers (byte offsets in the compat window):
//   0x70 ENABLE   event capture enable per source
//   0x74 PENDING  pending events, write-1-to-clear
//   0x78 MASK     1 = source masked from irq_o (reset all ones)
//   0x7C HOLDOFF  post-ack interrupt holdoff cycles, only with the
//                 CARBONIO_IRQ_COALESCE_EN build macro; unmapped otherwise
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   src_i                 raw source requests (synchronous to clk)
//   reg_wr_i/reg_rd_i     single-cycle register strobes
//   reg_addr_i/wdata_i    register offset and write data
//   reg_rdata_o/rvalid_o  registered read data, valid pulse 1 cycle after rd
//   irq_o                 interrupt request
//   irq_id_o/valid_o      lowest-index active source
//   irq_ack_i/ack_id_i    claim acknowledge, clears that source's pending bit
module carbonio_irq_ctrl
  import carbonio_pkg::*;
#(
  parameter int               N_SRC    = CARBONIO_IRQ_N_SRC,
  parameter logic [N_SRC-1:0] SRC_EDGE = N_SRC'(CARBONIO_IRQ_SRC_EDGE_DFLT)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SRC-1:0]             src_i,
  input  logic                         reg_wr_i,
  input  logic                         reg_rd_i,
  input  logic [7:0]                   reg_addr_i,
  input  logic [31:0]                  reg_wdata_i,
  output logic [31:0]                  reg_rdata_o,
  output logic                         reg_rvalid_o,
  output logic                         irq_o,
  output logic [CARBONIO_IRQ_ID_W-1:0] irq_id_o,
  output logic                         irq_id_valid_o,
  input  logic                         irq_ack_i,
  input  logic [CARBONIO_IRQ_ID_W-1:0] irq_ack_id_i
);

  localparam int         ID_W        = CARBONIO_IRQ_ID_W;
  localparam logic [7:0] OFF_ENABLE  = CARBONIO_COMPAT_IRQ_ENABLE_OFF[7:0];
  localparam logic [7:0] OFF_PENDING = CARBONIO_COMPAT_IRQ_PENDING_OFF[7:0];
  localparam logic [7:0] OFF_MASK    = CARBONIO_COMPAT_IRQ_MASK_OFF[7:0];

  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] src_prev_q;
  logic [N_SRC-1:0] evt, set_vec, clr_vec, active;

  logic [31:0]      rdata_q, rdata_d;
  logic             rvalid_q;
  logic             irq_q, irq_d;
  logic             id_valid_q, id_valid_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic [ID_W-1:0]  enc_idx;
  logic             enc_valid;
  logic             hold_zero;

  // Upper write-data bits are architecturally ignored
  logic unused_wdata;
  assign unused_wdata = ^reg_wdata_i;

  // Event capture and pending update. Set is OR'ed in after the clear so a
  // same-cycle set beats a W1C or ack on the same bit.
  always_comb begin
    evt     = (src_i & ~src_prev_q & SRC_EDGE) | (src_i & ~SRC_EDGE);
    set_vec = evt & enable_q;

    clr_vec = '0;
    if (reg_wr_i && (reg_addr_i == OFF_PENDING)) begin
      clr_vec = reg_wdata_i[N_SRC-1:0];
    end
    // Out-of-range ack IDs match no source and so are dropped here
    for (int i = 0; i < N_SRC; i++) begin
      if (irq_ack_i && (irq_ack_id_i == ID_W'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end

    pending_d = (pending_q & ~clr_vec) | set_vec;

    enable_d = enable_q;
    if (reg_wr_i && (reg_addr_i == OFF_ENABLE)) begin
      enable_d = reg_wdata_i[N_SRC-1:0];
    end

    mask_d = mask_q;
    if (reg_wr_i && (reg_addr_i == OFF_MASK)) begin
      mask_d = reg_wdata_i[N_SRC-1:0];
    end
  end

  assign active = pending_q & ~mask_q;

  carbonio_irq_prio_enc #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_prio_enc (
    .vec_i   (active),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

`ifdef CARBONIO_IRQ_COALESCE_EN
  localparam logic [7:0] OFF_HOLDOFF = CARBONIO_COMPAT_IRQ_HOLDOFF_OFF[7:0];

  logic [15:0] holdoff_q, holdoff_d;
  logic [15:0] hold_cnt_q, hold_cnt_d;

  // Every ack reloads the down-counter; it parks at zero
  always_comb begin
    holdoff_d = holdoff_q;
    if (reg_wr_i && (reg_addr_i == OFF_HOLDOFF)) begin
      holdoff_d = reg_wdata_i[15:0];
    end
    hold_cnt_d = hold_cnt_q;
    if (irq_ack_i) begin
      hold_cnt_d = holdoff_q;
    end else if (hold_cnt_q != 16'd0) begin
      hold_cnt_d = hold_cnt_q - 16'd1;
    end
  end

  assign hold_zero = (hold_cnt_q == 16'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdoff_q  <= '0;
      hold_cnt_q <= '0;
    end else begin
      holdoff_q  <= holdoff_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  assign hold_zero = 1'b1;
`endif

  // Read mux samples register state before this cycle's update, so a
  // same-cycle write to the read address returns the old value.
  always_comb begin
    rdata_d = '0;
    if (reg_rd_i) begin
      case (reg_addr_i)
        OFF_ENABLE:  rdata_d[N_SRC-1:0] = enable_q;
        OFF_PENDING: rdata_d[N_SRC-1:0] = pending_q;
        OFF_MASK:    rdata_d[N_SRC-1:0] = mask_q;
`ifdef CARBONIO_IRQ_COALESCE_EN
        OFF_HOLDOFF: rdata_d[15:0] = holdoff_q;
`endif
        default:     rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    irq_d      = enc_valid & hold_zero;
    id_valid_d = enc_valid & hold_zero;
    id_d       = enc_idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q   <= '0;
      pending_q  <= '0;
      mask_q     <= '1;
      src_prev_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      irq_q      <= 1'b0;
      id_valid_q <= 1'b0;
      id_q       <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      src_prev_q <= src_i;
      rdata_q    <= rdata_d;
      rvalid_q   <= reg_rd_i;
      irq_q      <= irq_d;
      id_valid_q <= id_valid_d;
      id_q       <= id_d;
    end
  end

  assign reg_rdata_o    = rdata_q;
  assign reg_rvalid_o   = rvalid_q;
  assign irq_o          = irq_q;
  assign irq_id_o       = id_q;
  assign irq_id_valid_o = id_valid_q;

endmodule
